// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage M-extension unit: funct3 operation codes,
// operand forwarding selects and the sequencer state type.
package ex_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM    = 2'b01;
  localparam logic [1:0] FWD_WB     = 2'b10;
  localparam logic [1:0] FWD_RF_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Restoring radix-2 divider on unsigned magnitudes. quo_nxt/rem_nxt expose the
// result of the current iteration so the caller can capture the final step directly.
module md_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quo_q starts as the dividend; its MSB shifts into the partial remainder
  // each step while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[XLEN]) begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit: one radix-2 step per cycle, stalls the
// front of the pipe while busy, and pulses md_done with a registered result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_valid_ex,
  input  logic [2:0]      md_op_ex,
  input  logic            flush_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic [XLEN-1:0] reg_write_data_mem,
  input  logic [XLEN-1:0] reg_write_data_wb,
  input  logic [1:0]      rs1_fwd_ex,
  input  logic [1:0]      rs2_fwd_ex,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              res_neg_q, res_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   md_result_q, md_result_d;

  logic [XLEN-1:0]   op_a, op_b, a_mag, b_mag, special_res, final_res;
  logic              a_neg, b_neg, div_zero, div_ovf, special, accept, last_iter;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt, prod_fin;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fin, rem_fin;

  // Operand selection and sign handling for the instruction currently in EX.
  always_comb begin
    case (rs1_fwd_ex)
      FWD_MEM: op_a = reg_write_data_mem;
      FWD_WB:  op_a = reg_write_data_wb;
      default: op_a = rs1_data_ex;
    endcase
    case (rs2_fwd_ex)
      FWD_MEM: op_b = reg_write_data_mem;
      FWD_WB:  op_b = reg_write_data_wb;
      default: op_b = rs2_data_ex;
    endcase
    a_neg = op_a[XLEN-1] & ((md_op_ex == OP_MULH) || (md_op_ex == OP_MULHSU) ||
                            is_signed_div(md_op_ex));
    b_neg = op_b[XLEN-1] & ((md_op_ex == OP_MULH) || is_signed_div(md_op_ex));
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
    div_zero = is_div_op(md_op_ex) && (op_b == '0);
    div_ovf  = is_signed_div(md_op_ex) && (op_a == MOST_NEG) && (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = is_rem_op(md_op_ex) ? op_a : '1;
    else          special_res = is_rem_op(md_op_ex) ? '0 : op_a;
  end

  assign accept    = (state_q == ST_IDLE) && md_valid_ex && !flush_ex;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  // Shift-add multiply: multiplier sits in the low half and drains out the
  // bottom while partial sums accumulate into the top half.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
  end

  md_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     ((state_q == ST_RUN) && is_div_op(op_q)),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_comb begin
    prod_fin = res_neg_q ? -prod_nxt : prod_nxt;
    quo_fin  = res_neg_q ? -quo_nxt : quo_nxt;
    rem_fin  = rem_neg_q ? -rem_nxt : rem_nxt;
    case (op_q)
      OP_MUL:                       final_res = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fin;
      default:                      final_res = rem_fin;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    if (accept) begin
      op_d      = md_op_ex;
      res_neg_d = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      mcand_d   = a_mag;
      prod_d    = {{XLEN{1'b0}}, b_mag};
    end else if ((state_q == ST_RUN) && !is_div_op(op_q)) begin
      prod_d = prod_nxt;
    end
  end

  // Sequencer: flush always wins; DONE lasts one cycle and never re-accepts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_result_d = md_result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (special) begin
            state_d     = ST_DONE;
            md_result_d = special_res;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush_ex) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d     = ST_DONE;
            md_result_d = final_res;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      res_neg_q   <= res_neg_d;
      rem_neg_q   <= rem_neg_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      md_result_q <= md_result_d;
    end
  end

  // rst_n is folded in so the stall drops the instant reset asserts.
  assign md_stall  = rst_n & md_valid_ex & ~flush_ex &
                     ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign md_done   = (state_q == ST_DONE);
  assign md_result = md_result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv (XLEN=32) against an arithmetic
// reference model, with latency, stall, flush and reset checks.
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        md_valid_ex;
  logic [2:0]  md_op_ex;
  logic        flush_ex;
  logic [31:0] rs1_data_ex, rs2_data_ex;
  logic [31:0] reg_write_data_mem, reg_write_data_wb;
  logic [1:0]  rs1_fwd_ex, rs2_fwd_ex;
  logic        md_stall, md_done;
  logic [31:0] md_result;

  int          vec_count;
  int          err_count;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  ex_muldiv #(.XLEN(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .md_valid_ex        (md_valid_ex),
    .md_op_ex           (md_op_ex),
    .flush_ex           (flush_ex),
    .rs1_data_ex        (rs1_data_ex),
    .rs2_data_ex        (rs2_data_ex),
    .reg_write_data_mem (reg_write_data_mem),
    .reg_write_data_wb  (reg_write_data_wb),
    .rs1_fwd_ex         (rs1_fwd_ex),
    .rs2_fwd_ex         (rs2_fwd_ex),
    .md_stall           (md_stall),
    .md_done            (md_done),
    .md_result          (md_result)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic idle_cycle();
    md_valid_ex = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_done", 32'(md_done), 32'd0);
    check_eq("idle_hold", md_result, last_result);
  endtask

  // scramble: 0 keep inputs, 1 randomize operand/forward inputs, 2 zero MEM/WB
  task automatic do_op(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] mem, input logic [31:0] wb,
                       input logic [1:0] f1, input logic [1:0] f2, input int scramble);
    logic [31:0] a, b, exp;
    bit          special;
    int          n;
    a = (f1 == 2'b01) ? mem : (f1 == 2'b10) ? wb : r1;
    b = (f2 == 2'b01) ? mem : (f2 == 2'b10) ? wb : r2;
    exp_q.push_back(ref_model(op, a, b));
    special = op[2] && ((b == 32'd0) ||
              (((op == 3'd4) || (op == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    md_valid_ex = 1'b1;
    md_op_ex = op;
    rs1_data_ex = r1;
    rs2_data_ex = r2;
    reg_write_data_mem = mem;
    reg_write_data_wb = wb;
    rs1_fwd_ex = f1;
    rs2_fwd_ex = f2;
    #1;
    n = 0;
    while (!md_stall && n < 4) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (n > 0) begin
      check_eq("done_pulse", 32'(md_done), 32'd0);
      check_eq("result_hold", md_result, last_result);
    end
    check_eq("stall_accept", 32'(md_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (scramble == 1) begin
      md_op_ex = 3'($urandom_range(0, 7));
      rs1_data_ex = $urandom;
      rs2_data_ex = $urandom;
      reg_write_data_mem = $urandom;
      reg_write_data_wb = $urandom;
      rs1_fwd_ex = 2'($urandom_range(0, 3));
      rs2_fwd_ex = 2'($urandom_range(0, 3));
    end else if (scramble == 2) begin
      reg_write_data_mem = 32'd0;
      reg_write_data_wb = 32'd0;
    end
    n = 0;
    while (!md_done && n < 40) begin
      check_eq("stall_run", 32'(md_stall), 32'd1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), special ? 32'd0 : 32'd32);
    check_eq("done", 32'(md_done), 32'd1);
    check_eq("stall_done", 32'(md_stall), 32'd0);
    exp = exp_q.pop_front();
    check_eq($sformatf("result_op%0d", op), md_result, exp);
    last_result = exp;
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (md_done) pulses++;
    end
    check_eq(tag, 32'(pulses), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_count = 0;
    err_count = 0;
    last_result = 32'd0;
    rst_n = 1'b0;
    md_valid_ex = 1'b1;
    md_op_ex = 3'd0;
    flush_ex = 1'b0;
    rs1_data_ex = 32'd3;
    rs2_data_ex = 32'd4;
    reg_write_data_mem = 32'd0;
    reg_write_data_wb = 32'd0;
    rs1_fwd_ex = 2'b00;
    rs2_fwd_ex = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("rst_result", md_result, 32'd0);
    check_eq("rst_done", 32'(md_done), 32'd0);
    check_eq("rst_stall", 32'(md_stall), 32'd0);
    md_valid_ex = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic, chained back to back
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd4, 32'd1000, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd5, 32'd100, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd7, 32'd100, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd5, 32'd5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd6, 32'd5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 0);
    idle_cycle();

    // Forwarded operands that change after acceptance
    do_op(3'd5, 32'd55, 32'd66, 32'd100, 32'd9, 2'b01, 2'b10, 2);
    idle_cycle();

    // Flush part-way through a multiply
    md_valid_ex = 1'b1;
    md_op_ex = 3'd0;
    rs1_data_ex = 32'd3;
    rs2_data_ex = 32'd5;
    rs1_fwd_ex = 2'b00;
    rs2_fwd_ex = 2'b00;
    @(posedge clk);
    @(negedge clk);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush_ex = 1'b1;
    #1;
    check_eq("stall_flush", 32'(md_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush_ex = 1'b0;
    check_eq("flush_done", 32'(md_done), 32'd0);
    md_valid_ex = 1'b0;
    watch_no_done("flush_no_done", 40);
    check_eq("flush_hold", md_result, last_result);

    // Reset part-way through a divide
    md_valid_ex = 1'b1;
    md_op_ex = 3'd4;
    rs1_data_ex = 32'd1000;
    rs2_data_ex = 32'd3;
    @(posedge clk);
    @(negedge clk);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_result", md_result, 32'd0);
    check_eq("midrst_done", 32'(md_done), 32'd0);
    check_eq("midrst_stall", 32'(md_stall), 32'd0);
    md_valid_ex = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_result = 32'd0;
    watch_no_done("rst_no_done", 40);
    check_eq("rst_hold", md_result, 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      do_op(3'($urandom_range(0, 7)), rand_val(), rand_val(), rand_val(), rand_val(),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
